mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-stage consumer of the EX/MEM pipeline latch outputs.
- Issues data-memory read/write requests to a multi-cycle data memory with a done handshake.
- Generates the pipeline stall that freezes the EX/MEM latch and all upstream stages.
- Contains the MEM/WB pipeline latch, which inserts bubbles while a memory access is outstanding.

Parameters:
TIMEOUT, 64, max WAIT cycles before an access is abandoned (range 2..255)
STALL_CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low (0 = reset, sampled on rising clk)
ALURes_EX_MEM  in  16  memory address / ALU result
rdData2_EX_MEM  in  16  store data
PC_2_EX_MEM  in  16  PC+2 of instruction in MEM
writeRegSel_EX_MEM  in  3  destination register
isNotHalt_EX_MEM  in  1  0 = HALT instruction
isMemToReg_EX_MEM  in  1  writeback selects memory data
isMemRead_EX_MEM  in  1  load
isMemWrite_EX_MEM  in  1  store
isRegWrite_EX_MEM  in  1  register write enable
mem_addr  out  16  = ALURes_EX_MEM
mem_wdata  out  16  = rdData2_EX_MEM
mem_rd  out  1  read request strobe
mem_wr  out  1  write request strobe
mem_rdata  in  16  read data, valid when mem_done=1
mem_done  in  1  access complete (may be same cycle as the request)
stall_mem  out  1  1 = hold EX/MEM and upstream (EX/MEM en = ~stall_mem)
memData_MEM_WB  out  16  registered load data
ALURes_MEM_WB  out  16  registered ALU result
PC_2_MEM_WB  out  16  registered PC+2
writeRegSel_MEM_WB  out  3  registered destination register
isNotHalt_MEM_WB  out  1  registered not-halt
isMemToReg_MEM_WB  out  1  registered mem-to-reg select
isRegWrite_MEM_WB  out  1  registered register write enable
mem_err  out  1  sticky error flag
stall_cycles  out  STALL_CNT_W  saturating count of stall cycles

Behaviour:
- Reset (rst=0 at a clock edge):
  - FSM goes to IDLE; wait counter = 0; mem_err = 0; stall_cycles = 0.
  - All MEM/WB outputs go to 0, except isNotHalt_MEM_WB = 1, so reset is not taken as a halt.
- A reset asserted mid-access abandons the access; the memory sees no further strobes.
- op = isNotHalt_EX_MEM & (isMemRead_EX_MEM | isMemWrite_EX_MEM). No requests are issued for a HALT instruction.
- FSM state IDLE:
  - mem_wr = op & isMemWrite_EX_MEM.
  - mem_rd = op & isMemRead_EX_MEM & ~isMemWrite_EX_MEM.
  - If read and write are both 1, the write takes priority and mem_err is set.
  - No op: stall_mem = 0.
  - op with mem_done = 1 in the same cycle: zero-stall hit, stall_mem = 0, stay in IDLE.
  - op with mem_done = 0: stall_mem = 1, next state is WAIT, wait counter = 1.
- FSM state WAIT:
  - mem_rd = mem_wr = 0 (single-cycle strobe; the memory holds the request). mem_addr and mem_wdata stay stable because EX/MEM is frozen.
  - mem_done = 1: stall_mem = 0, next state is IDLE.
  - mem_done = 0 and wait counter = TIMEOUT: stall_mem = 0, mem_err is set, the access completes with memData = 0x0000, next state is IDLE.
  - Otherwise: stall_mem = 1 and the wait counter increments.
- stall_mem is combinational from the state, the EX/MEM inputs and mem_done.
- MEM/WB latch, sampled each edge:
  - stall_mem = 0: capture the EX/MEM fields.
  - memData_MEM_WB = mem_rdata when a read completes with done; 0x0000 on a timeout; otherwise the prior value is held.
  - stall_mem = 1: capture a bubble: isRegWrite = 0, isMemToReg = 0, isNotHalt = 1, other fields unchanged.
- Latency: a zero-wait access reaches the MEM/WB outputs 1 cycle after it is presented. An N-wait access takes N+1 cycles, with N bubbles.
- stall_cycles increments on each cycle with stall_mem = 1 and saturates at all-ones.
- mem_err is cleared only by reset.

Test Plan:
- Reset, then release: all MEM/WB outputs 0, isNotHalt_MEM_WB = 1, stall_mem = 0, mem_err = 0.
- Load with ALURes = 0x0040, mem_done = 1 in the same cycle, mem_rdata = 0xBEEF:
  - mem_rd pulses 1 cycle, no stall.
  - Next cycle: memData_MEM_WB = 0xBEEF, isMemToReg = 1, isRegWrite = 1.
- Store with ALURes = 0x0010, rdData2 = 0x1234, mem_done rising 3 cycles after the request:
  - mem_wr for 1 cycle; stall_mem = 1 for 3 cycles; mem_addr/mem_wdata stable throughout.
  - 3 bubbles with isRegWrite_MEM_WB = 0; then the store retires; stall_cycles = 3.
- TIMEOUT = 4, load with mem_done never asserted:
  - stall for 4 cycles, then release; mem_err = 1 (sticky); memData_MEM_WB = 0x0000.
- HALT with isMemRead = 1: no mem_rd; next cycle isNotHalt_MEM_WB = 0.
- Read and write both 1: only mem_wr is asserted; mem_err = 1.
- rst = 0 during WAIT: back to IDLE, stall_mem = 0, and no new strobe on the cycle after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage that drives a multi-cycle data memory, stalls the pipeline
// while an access is outstanding and holds the MEM/WB latch.
module mem_access_unit #(
   parameter int TIMEOUT     = 64,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [15:0]            ALURes_EX_MEM,
   input  logic [15:0]            rdData2_EX_MEM,
   input  logic [15:0]            PC_2_EX_MEM,
   input  logic [2:0]             writeRegSel_EX_MEM,
   input  logic                   isNotHalt_EX_MEM,
   input  logic                   isMemToReg_EX_MEM,
   input  logic                   isMemRead_EX_MEM,
   input  logic                   isMemWrite_EX_MEM,
   input  logic                   isRegWrite_EX_MEM,
   output logic [15:0]            mem_addr,
   output logic [15:0]            mem_wdata,
   output logic                   mem_rd,
   output logic                   mem_wr,
   input  logic [15:0]            mem_rdata,
   input  logic                   mem_done,
   output logic                   stall_mem,
   output logic [15:0]            memData_MEM_WB,
   output logic [15:0]            ALURes_MEM_WB,
   output logic [15:0]            PC_2_MEM_WB,
   output logic [2:0]             writeRegSel_MEM_WB,
   output logic                   isNotHalt_MEM_WB,
   output logic                   isMemToReg_MEM_WB,
   output logic                   isRegWrite_MEM_WB,
   output logic                   mem_err,
   output logic [STALL_CNT_W-1:0] stall_cycles
);
   typedef enum logic {IDLE, WAIT} state_t;
   state_t     state, state_nxt;
   logic [7:0] wait_cnt;
   logic       op, timeout, pend_rd, done_rd;
   assign op        = isNotHalt_EX_MEM & (isMemRead_EX_MEM | isMemWrite_EX_MEM);
   assign timeout   = (state == WAIT) & ~mem_done & (wait_cnt == 8'(TIMEOUT));
   assign mem_addr  = ALURes_EX_MEM;
   assign mem_wdata = rdData2_EX_MEM;
   assign done_rd   = mem_done & ((state == IDLE) ? mem_rd : pend_rd);
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end
   always_comb begin
      state_nxt = state;
      if (state == IDLE) state_nxt = (op & ~mem_done) ? WAIT : IDLE;
      else               state_nxt = (mem_done | timeout) ? IDLE : WAIT;
   end
   // strobes are gated by reset so an abandoned access sees nothing further
   always_comb begin
      mem_wr    = 1'b0;
      mem_rd    = 1'b0;
      stall_mem = 1'b0;
      if (rst && state == IDLE) begin
         mem_wr    = op & isMemWrite_EX_MEM;
         mem_rd    = op & isMemRead_EX_MEM & ~isMemWrite_EX_MEM;
         stall_mem = op & ~mem_done;
      end else if (rst) begin
         stall_mem = ~mem_done & ~timeout;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         wait_cnt     <= '0;
         pend_rd      <= 1'b0;
         mem_err      <= 1'b0;
         stall_cycles <= '0;
      end else begin
         wait_cnt <= (state_nxt == WAIT) ? ((state == IDLE) ? 8'd1 : wait_cnt + 8'd1) : 8'd0;
         if (state == IDLE) pend_rd <= mem_rd;
         if (timeout | ((state == IDLE) & isNotHalt_EX_MEM & isMemRead_EX_MEM & isMemWrite_EX_MEM))
            mem_err <= 1'b1;
         if (stall_mem & ~&stall_cycles) stall_cycles <= stall_cycles + STALL_CNT_W'(1);
      end
   end
   // a stalled cycle turns the MEM/WB entry into a bubble
   always_ff @(posedge clk) begin
      if (!rst) begin
         memData_MEM_WB     <= '0;
         ALURes_MEM_WB      <= '0;
         PC_2_MEM_WB        <= '0;
         writeRegSel_MEM_WB <= '0;
         isNotHalt_MEM_WB   <= 1'b1;
         isMemToReg_MEM_WB  <= 1'b0;
         isRegWrite_MEM_WB  <= 1'b0;
      end else begin
         if (done_rd)      memData_MEM_WB <= mem_rdata;
         else if (timeout) memData_MEM_WB <= '0;
         if (stall_mem) begin
            isNotHalt_MEM_WB  <= 1'b1;
            isMemToReg_MEM_WB <= 1'b0;
            isRegWrite_MEM_WB <= 1'b0;
         end else begin
            ALURes_MEM_WB      <= ALURes_EX_MEM;
            PC_2_MEM_WB        <= PC_2_EX_MEM;
            writeRegSel_MEM_WB <= writeRegSel_EX_MEM;
            isNotHalt_MEM_WB   <= isNotHalt_EX_MEM;
            isMemToReg_MEM_WB  <= isMemToReg_EX_MEM;
            isRegWrite_MEM_WB  <= isRegWrite_EX_MEM;
         end
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of the memory stage with TIMEOUT=4.
module tb_mem_access_unit;
   logic        clk, rst;
   logic [15:0] alu, wd, pc, mem_addr, mem_wdata, mem_rdata;
   logic [2:0]  sel;
   logic        nh, m2r, rd, wr, rw;
   logic        mem_rd, mem_wr, mem_done, stall_mem;
   logic [15:0] md_wb, alu_wb, pc_wb;
   logic [2:0]  sel_wb;
   logic        nh_wb, m2r_wb, rw_wb, mem_err;
   logic [15:0] stall_cycles;
   int checks = 0, failures = 0;

   mem_access_unit #(.TIMEOUT(4), .STALL_CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .ALURes_EX_MEM(alu), .rdData2_EX_MEM(wd), .PC_2_EX_MEM(pc), .writeRegSel_EX_MEM(sel),
      .isNotHalt_EX_MEM(nh), .isMemToReg_EX_MEM(m2r), .isMemRead_EX_MEM(rd),
      .isMemWrite_EX_MEM(wr), .isRegWrite_EX_MEM(rw),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_rdata(mem_rdata), .mem_done(mem_done), .stall_mem(stall_mem),
      .memData_MEM_WB(md_wb), .ALURes_MEM_WB(alu_wb), .PC_2_MEM_WB(pc_wb),
      .writeRegSel_MEM_WB(sel_wb), .isNotHalt_MEM_WB(nh_wb), .isMemToReg_MEM_WB(m2r_wb),
      .isRegWrite_MEM_WB(rw_wb), .mem_err(mem_err), .stall_cycles(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic [15:0] a, input logic [15:0] d, input logic [15:0] p,
                         input logic [2:0] s, input logic h, input logic m, input logic r,
                         input logic w, input logic g);
      alu = a; wd = d; pc = p; sel = s; nh = h; m2r = m; rd = r; wr = w; rw = g;
   endtask

   task automatic apply_reset();
      rst = 1'b0; mem_done = 1'b0; mem_rdata = '0;
      set_ex(0, 0, 0, 0, 1, 0, 0, 0, 0);
      step(); step();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      checks++; if (md_wb !== 16'h0) begin failures++; $display("FAIL reset_memdata got=%h exp=0000", md_wb); end
      checks++; if ({alu_wb, pc_wb, sel_wb} !== 35'h0) begin failures++; $display("FAIL reset_fields got=%h/%h/%h exp=0", alu_wb, pc_wb, sel_wb); end
      checks++; if ({nh_wb, m2r_wb, rw_wb} !== 3'b100) begin failures++; $display("FAIL reset_flags got=%b exp=100", {nh_wb, m2r_wb, rw_wb}); end
      checks++; if ({stall_mem, mem_err, mem_rd, mem_wr} !== 4'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=0000", {stall_mem, mem_err, mem_rd, mem_wr}); end
      checks++; if (stall_cycles !== 16'd0) begin failures++; $display("FAIL reset_stallcnt got=%0d exp=0", stall_cycles); end
   endtask

   task automatic test_load_hit();
      set_ex(16'h0040, 0, 16'h0102, 3, 1, 1, 1, 0, 1);
      mem_done = 1'b1; mem_rdata = 16'hBEEF;
      #1;
      checks++; if ({mem_rd, mem_wr, stall_mem} !== 3'b100) begin failures++; $display("FAIL load_strobe got=%b exp=100", {mem_rd, mem_wr, stall_mem}); end
      checks++; if (mem_addr !== 16'h0040) begin failures++; $display("FAIL load_addr got=%h exp=0040", mem_addr); end
      step();
      set_ex(0, 0, 0, 0, 1, 0, 0, 0, 0);
      mem_done = 1'b0; mem_rdata = 16'h0;
      #1;
      checks++; if (md_wb !== 16'hBEEF) begin failures++; $display("FAIL load_data got=%h exp=beef", md_wb); end
      checks++; if ({m2r_wb, rw_wb, nh_wb} !== 3'b111) begin failures++; $display("FAIL load_flags got=%b exp=111", {m2r_wb, rw_wb, nh_wb}); end
      checks++; if ({alu_wb, pc_wb, sel_wb} !== {16'h0040, 16'h0102, 3'd3}) begin failures++; $display("FAIL load_fields got=%h/%h/%h exp=0040/0102/3", alu_wb, pc_wb, sel_wb); end
      checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL load_rd_pulse got=%b exp=0", mem_rd); end
   endtask

   task automatic test_back_to_back();
      set_ex(16'h0001, 0, 16'h0010, 1, 1, 1, 1, 0, 1);
      mem_done = 1'b1; mem_rdata = 16'h1111;
      step();
      set_ex(16'h0002, 0, 16'h0012, 2, 1, 1, 1, 0, 1);
      mem_rdata = 16'h2222;
      #1;
      checks++; if ({md_wb, alu_wb, stall_mem} !== {16'h1111, 16'h0001, 1'b0}) begin failures++; $display("FAIL b2b_first got=%h/%h/%b exp=1111/0001/0", md_wb, alu_wb, stall_mem); end
      step();
      set_ex(0, 0, 0, 0, 1, 0, 0, 0, 0);
      mem_done = 1'b0;
      #1;
      checks++; if ({md_wb, alu_wb, sel_wb} !== {16'h2222, 16'h0002, 3'd2}) begin failures++; $display("FAIL b2b_second got=%h/%h/%h exp=2222/0002/2", md_wb, alu_wb, sel_wb); end
   endtask

   task automatic test_store_wait();
      set_ex(16'h0010, 16'h1234, 16'h0200, 5, 1, 0, 0, 1, 0);
      mem_done = 1'b0;
      #1;
      checks++; if ({mem_wr, mem_rd, stall_mem} !== 3'b101) begin failures++; $display("FAIL store_req got=%b exp=101", {mem_wr, mem_rd, stall_mem}); end
      for (int i = 1; i <= 2; i++) begin
         step();
         #1;
         checks++; if ({mem_wr, mem_rd, stall_mem} !== 3'b001) begin failures++; $display("FAIL store_wait%0d got=%b exp=001", i, {mem_wr, mem_rd, stall_mem}); end
         checks++; if ({mem_addr, mem_wdata} !== {16'h0010, 16'h1234}) begin failures++; $display("FAIL store_stable%0d got=%h/%h exp=0010/1234", i, mem_addr, mem_wdata); end
         checks++; if ({rw_wb, nh_wb, pc_wb} !== {1'b0, 1'b1, 16'h0012}) begin failures++; $display("FAIL store_bubble%0d got=%b/%b/%h exp=0/1/0012", i, rw_wb, nh_wb, pc_wb); end
      end
      step();
      mem_done = 1'b1;
      #1;
      checks++; if ({mem_wr, mem_rd, stall_mem} !== 3'b000) begin failures++; $display("FAIL store_done got=%b exp=000", {mem_wr, mem_rd, stall_mem}); end
      checks++; if (rw_wb !== 1'b0) begin failures++; $display("FAIL store_bubble3 got=%b exp=0", rw_wb); end
      step();
      set_ex(0, 0, 0, 0, 1, 0, 0, 0, 0);
      mem_done = 1'b0;
      #1;
      checks++; if ({alu_wb, pc_wb, sel_wb} !== {16'h0010, 16'h0200, 3'd5}) begin failures++; $display("FAIL store_retire got=%h/%h/%h exp=0010/0200/5", alu_wb, pc_wb, sel_wb); end
      checks++; if (md_wb !== 16'h2222) begin failures++; $display("FAIL store_memdata_hold got=%h exp=2222", md_wb); end
      checks++; if (stall_cycles !== 16'd3) begin failures++; $display("FAIL store_stallcnt got=%0d exp=3", stall_cycles); end
      checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL store_err got=%b exp=0", mem_err); end
   endtask

   task automatic test_timeout();
      set_ex(16'h0080, 0, 16'h0300, 2, 1, 1, 1, 0, 1);
      mem_done = 1'b0; mem_rdata = 16'h5555;
      #1;
      checks++; if ({mem_rd, stall_mem} !== 2'b11) begin failures++; $display("FAIL to_req got=%b exp=11", {mem_rd, stall_mem}); end
      for (int i = 1; i <= 3; i++) begin
         step();
         #1;
         checks++; if ({mem_rd, stall_mem} !== 2'b01) begin failures++; $display("FAIL to_wait%0d got=%b exp=01", i, {mem_rd, stall_mem}); end
      end
      step();
      #1;
      checks++; if (stall_mem !== 1'b0) begin failures++; $display("FAIL to_release got=%b exp=0", stall_mem); end
      step();
      set_ex(0, 0, 0, 0, 1, 0, 0, 0, 0);
      #1;
      checks++; if ({md_wb, alu_wb, rw_wb} !== {16'h0000, 16'h0080, 1'b1}) begin failures++; $display("FAIL to_complete got=%h/%h/%b exp=0000/0080/1", md_wb, alu_wb, rw_wb); end
      checks++; if (mem_err !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", mem_err); end
      checks++; if (stall_cycles !== 16'd7) begin failures++; $display("FAIL to_stallcnt got=%0d exp=7", stall_cycles); end
      step(); step();
      checks++; if (mem_err !== 1'b1) begin failures++; $display("FAIL to_err_sticky got=%b exp=1", mem_err); end
   endtask

   task automatic test_halt();
      set_ex(16'h0040, 0, 16'h0400, 1, 0, 1, 1, 0, 1);
      mem_done = 1'b0;
      #1;
      checks++; if ({mem_rd, mem_wr, stall_mem} !== 3'b000) begin failures++; $display("FAIL halt_strobe got=%b exp=000", {mem_rd, mem_wr, stall_mem}); end
      step();
      set_ex(0, 0, 0, 0, 1, 0, 0, 0, 0);
      #1;
      checks++; if ({nh_wb, pc_wb} !== {1'b0, 16'h0400}) begin failures++; $display("FAIL halt_wb got=%b/%h exp=0/0400", nh_wb, pc_wb); end
   endtask

   task automatic test_rd_wr_conflict();
      apply_reset();
      set_ex(16'h0020, 16'hAAAA, 16'h0500, 4, 1, 0, 1, 1, 0);
      mem_done = 1'b1; mem_rdata = 16'h7777;
      #1;
      checks++; if ({mem_wr, mem_rd, stall_mem} !== 3'b100) begin failures++; $display("FAIL rdwr_strobe got=%b exp=100", {mem_wr, mem_rd, stall_mem}); end
      step();
      set_ex(0, 0, 0, 0, 1, 0, 0, 0, 0);
      mem_done = 1'b0;
      #1;
      checks++; if (mem_err !== 1'b1) begin failures++; $display("FAIL rdwr_err got=%b exp=1", mem_err); end
      checks++; if (md_wb !== 16'h0000) begin failures++; $display("FAIL rdwr_memdata got=%h exp=0000", md_wb); end
   endtask

   task automatic test_reset_mid_access();
      set_ex(16'h0060, 0, 16'h0600, 6, 1, 1, 1, 0, 1);
      mem_done = 1'b0;
      step(); step();
      checks++; if (stall_mem !== 1'b1) begin failures++; $display("FAIL mid_stall got=%b exp=1", stall_mem); end
      rst = 1'b0;
      set_ex(0, 0, 0, 0, 1, 0, 0, 0, 0);
      #1;
      checks++; if ({stall_mem, mem_rd, mem_wr} !== 3'b000) begin failures++; $display("FAIL mid_inreset got=%b exp=000", {stall_mem, mem_rd, mem_wr}); end
      step();
      rst = 1'b1;
      #1;
      checks++; if ({stall_mem, mem_rd, mem_wr, mem_err} !== 4'b0000) begin failures++; $display("FAIL mid_release got=%b exp=0000", {stall_mem, mem_rd, mem_wr, mem_err}); end
      checks++; if ({stall_cycles, nh_wb} !== {16'd0, 1'b1}) begin failures++; $display("FAIL mid_state got=%0d/%b exp=0/1", stall_cycles, nh_wb); end
      step();
      checks++; if ({stall_mem, mem_rd, mem_wr} !== 3'b000) begin failures++; $display("FAIL mid_after got=%b exp=000", {stall_mem, mem_rd, mem_wr}); end
   endtask

   initial begin
      test_reset();
      test_load_hit();
      test_back_to_back();
      test_store_wait();
      test_timeout();
      test_halt();
      test_rd_wr_conflict();
      test_reset_mid_access();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
